// File: rtl/spi_cmd_ctrl.sv
// SPI command decoder for the analog front-end: 3-byte frames (cmd, addr, data)
// drive select registers, timed relay coil pulses and a status/readback path.
module spi_cmd_ctrl #(
  parameter int         RELAY_PULSE = 48000,
  parameter logic [7:0] CMD_WR      = 8'h01,
  parameter logic [7:0] CMD_RD      = 8'h02
) (
  input  logic       clk_12mhz,
  input  logic       rst,
  input  logic       frame_active,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic [7:0] tx_data,
  output logic       tx_load,
  output logic [1:0] input_sel,
  output logic [1:0] mu_sel,
  output logic       avk_sel,
  output logic       fil1_sel,
  output logic       fil2_sel,
  output logic [7:0] relay_code,
  output logic       relay_cs,
  output logic       relay_reset,
  output logic       busy,
  output logic       err
);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, APPLY, RELAY, WAIT_END} state_t;

  localparam logic [15:0] PULSE_LAST = 16'(RELAY_PULSE - 1);

  state_t      state, state_nxt;
  logic [7:0]  cmd, addr, data;
  logic [15:0] relay_cnt;
  logic        stat_rd;
  logic        err_set, cmd_ld, addr_ld, data_ld, rd_ld;
  logic        apply_reg, relay_start, relay_done;

  function automatic logic is_rd_addr(input logic [7:0] a);
    case (a)
      8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h21, 8'h22, 8'h30: is_rd_addr = 1'b1;
      default:                                                is_rd_addr = 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] rd_val(input logic [7:0] a);
    case (a)
      8'h11:        rd_val = {6'b0, input_sel};
      8'h12:        rd_val = {6'b0, mu_sel};
      8'h13:        rd_val = {7'b0, avk_sel};
      8'h14:        rd_val = {7'b0, fil1_sel};
      8'h15:        rd_val = {7'b0, fil2_sel};
      8'h21, 8'h22: rd_val = relay_code;
      8'h30:        rd_val = {busy, err, 6'b0};
      default:      rd_val = 8'h00;
    endcase
  endfunction

  always_ff @(posedge clk_12mhz) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    err_set     = 1'b0;
    cmd_ld      = 1'b0;
    addr_ld     = 1'b0;
    data_ld     = 1'b0;
    rd_ld       = 1'b0;
    apply_reg   = 1'b0;
    relay_start = 1'b0;
    relay_done  = 1'b0;
    case (state)
      IDLE: begin
        if (rx_valid && frame_active) begin
          cmd_ld = 1'b1;
          if (rx_data == CMD_WR || rx_data == CMD_RD) begin
            state_nxt = ADDR;
          end else begin
            err_set   = 1'b1;
            state_nxt = WAIT_END;
          end
        end
      end
      ADDR: begin
        if (!frame_active) begin
          state_nxt = IDLE;
        end else if (rx_valid) begin
          addr_ld   = 1'b1;
          state_nxt = DATA;
          if (cmd == CMD_RD) begin
            rd_ld   = 1'b1;
            err_set = !is_rd_addr(rx_data);
          end
        end
      end
      DATA: begin
        if (!frame_active) begin
          state_nxt = IDLE;
        end else if (rx_valid) begin
          data_ld   = 1'b1;
          state_nxt = (cmd == CMD_WR) ? APPLY : WAIT_END;
        end
      end
      APPLY: begin
        case (addr)
          8'h11, 8'h12, 8'h13, 8'h14, 8'h15: begin
            apply_reg = 1'b1;
            state_nxt = WAIT_END;
          end
          8'h21, 8'h22: begin
            relay_start = 1'b1;
            state_nxt   = RELAY;
          end
          default: begin
            err_set   = 1'b1;
            state_nxt = WAIT_END;
          end
        endcase
      end
      RELAY: begin
        // The pulse ignores the frame; stray bytes only flag an error.
        err_set = rx_valid;
        if (relay_cnt == PULSE_LAST) begin
          relay_done = 1'b1;
          state_nxt  = WAIT_END;
        end
      end
      WAIT_END: begin
        if (!frame_active) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_12mhz) begin
    if (rst) begin
      tx_data     <= 8'h00;
      tx_load     <= 1'b0;
      stat_rd     <= 1'b0;
      cmd         <= 8'h00;
      addr        <= 8'h00;
      data        <= 8'h00;
      input_sel   <= 2'b00;
      mu_sel      <= 2'b00;
      avk_sel     <= 1'b0;
      fil1_sel    <= 1'b0;
      fil2_sel    <= 1'b0;
      relay_code  <= 8'h00;
      relay_cs    <= 1'b0;
      relay_reset <= 1'b0;
      busy        <= 1'b0;
      relay_cnt   <= 16'd0;
      err         <= 1'b0;
    end else begin
      tx_load <= rd_ld;
      stat_rd <= rd_ld && (rx_data == 8'h30);
      if (rd_ld)   tx_data <= rd_val(rx_data);
      if (cmd_ld)  cmd     <= rx_data;
      if (addr_ld) addr    <= rx_data;
      if (data_ld) data    <= rx_data;
      if (apply_reg) begin
        case (addr)
          8'h11:   input_sel <= data[1:0];
          8'h12:   mu_sel    <= data[1:0];
          8'h13:   avk_sel   <= data[0];
          8'h14:   fil1_sel  <= data[0];
          default: fil2_sel  <= data[0];
        endcase
      end
      // relay_code is left holding its pattern once the pulse ends.
      if (relay_start) begin
        relay_code  <= data;
        relay_reset <= (addr == 8'h22);
        relay_cs    <= 1'b1;
        busy        <= 1'b1;
        relay_cnt   <= 16'd0;
      end else if (relay_done) begin
        relay_cs    <= 1'b0;
        relay_reset <= 1'b0;
        busy        <= 1'b0;
        relay_cnt   <= 16'd0;
      end else if (state == RELAY) begin
        relay_cnt <= relay_cnt + 16'd1;
      end
      if (err_set)                err <= 1'b1;
      else if (tx_load && stat_rd) err <= 1'b0;
    end
  end

endmodule

// File: doc/spi_cmd_ctrl.md
SPI_CMD_CTRL -- requirements
Module: spi_cmd_ctrl

Interface
REQ-001 Parameter RELAY_PULSE, default 48000, relay coil pulse length in clk_12mhz cycles (4 ms).
REQ-002 Parameter CMD_WR, default 8'h01, write command code.
REQ-003 Parameter CMD_RD, default 8'h02, read command code.
REQ-004 clk_12mhz  input  1  sole clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 frame_active  input  1  high while SPI chip-select is asserted, already synchronised to clk_12mhz.
REQ-007 rx_valid  input  1  one-cycle strobe: a received SPI byte is on rx_data.
REQ-008 rx_data  input  8  received byte.
REQ-009 tx_data  output  8  byte for the SPI slave to shift out next.
REQ-010 tx_load  output  1  one-cycle strobe: tx_data valid.
REQ-011 input_sel  output  2, mu_sel  output  2, avk_sel  output  1, fil1_sel  output  1, fil2_sel  output  1  analog front-end select registers.
REQ-012 relay_code  output  8  relay pattern; relay_cs  output  1  relay strobe; relay_reset  output  1  1 = reset-coil pulse.
REQ-013 busy  output  1  high while a relay pulse runs; err  output  1  sticky status error.

Function
REQ-014 Frame = 3 bytes within one frame_active high period: byte0 command, byte1 address, byte2 data.
REQ-015 FSM states: IDLE, ADDR, DATA, APPLY, RELAY, WAIT_END.
REQ-016 IDLE: rx_valid with frame_active=1 -> latch cmd; cmd equal to CMD_WR or CMD_RD -> ADDR, else set err -> WAIT_END.
REQ-017 ADDR: rx_valid -> latch addr -> DATA; on CMD_RD the next cycle drives tx_data = selected register value with tx_load=1 for exactly one cycle.
REQ-018 DATA: rx_valid -> latch data; CMD_WR -> APPLY; CMD_RD -> WAIT_END, data discarded.
REQ-019 Address map (write data bits LSB-aligned, excess bits ignored): 0x11 input_sel[1:0], 0x12 mu_sel[1:0], 0x13 avk_sel, 0x14 fil1_sel, 0x15 fil2_sel, 0x21 relay set, 0x22 relay reset, 0x30 status (read-only).
REQ-020 APPLY (one cycle): 0x11-0x15 -> register updated at end of APPLY, -> WAIT_END; 0x21/0x22 -> relay_code=data, relay_reset=(addr==0x22), -> RELAY; any other address, or write to 0x30 -> set err, no register change, -> WAIT_END.
REQ-021 RELAY: relay_cs=1 and busy=1 for exactly RELAY_PULSE cycles, counted by 16-bit counter; then relay_cs=0, relay_reset=0, busy=0 in the same cycle -> WAIT_END; relay_code holds its value.
REQ-022 RELAY runs to completion independently of frame_active; rx_valid during RELAY is ignored and sets err.
REQ-023 Status read (0x30) returns {busy, err, 6'b0} and clears err the cycle after tx_load; read of undefined address returns 8'h00 and sets err.
REQ-024 Read of 0x11-0x15 returns register zero-extended to 8 bits; 0x21/0x22 return relay_code.
REQ-025 WAIT_END: additional rx_valid bytes ignored; frame_active=0 -> IDLE.
REQ-026 frame_active falling in ADDR or DATA -> IDLE next cycle, no register change, err unchanged.
REQ-027 rx_valid with frame_active=0 in IDLE is ignored.
REQ-028 err is sticky; only rst or a status read clears it; set takes priority over clear in the same cycle.

Reset
REQ-029 rst=1 at a clock edge -> state IDLE, relay counter 0, all outputs 0 (tx_data 8'h00, all selects 0, relay_code 0, relay_cs 0, relay_reset 0, busy 0, err 0), effective next cycle.
REQ-030 rst mid-frame or mid-RELAY aborts immediately; relay_cs low the cycle after rst.

Verification
REQ-031 Frame 01,11,03 -> input_sel=2'b11 after APPLY; other outputs unchanged; err=0.
REQ-032 Frame 01,21,A5 (RELAY_PULSE=10 in bench) -> relay_code=8'hA5, relay_cs=1 and busy=1 exactly 10 cycles, relay_reset=0; frame 01,22,5A -> relay_reset=1 during pulse.
REQ-033 Frame 01,11,02 then 02,11,xx -> tx_load one cycle after second byte with tx_data=8'h02.
REQ-034 Frame 07,11,01 -> err=1, no change; then 02,30,00 -> tx_data=8'h40, err=0 afterwards.
REQ-035 frame_active dropped after 2 bytes of 01,12,xx -> mu_sel unchanged, FSM IDLE; next full frame 01,12,01 -> mu_sel=2'b01.
REQ-036 rst asserted 3 cycles into a relay pulse -> relay_cs=0, busy=0, relay_code=0 next cycle.
